multi_cycle_processor: RTL and testbench
========================================

// Module: multi_cycle_processor
// PURPOSE
//  Multicycle RV32 core: the successor to the single-cycle core. Executes lw, sw, add/sub/and/or/slt,
//  addi/andi/ori/slti, beq, jal, and optionally bne, through one shared memory port for instructions and data.
//  The memory port uses a req/ready handshake, so arbitrary wait states are supported.
//  Illegal or misaligned operations halt the core instead of producing X.
// PARAMETERS
//  RESET_PC  32'h0000_0000  byte address of the first fetch after reset (word aligned)
//  ADDR_W    32             width of mem_addr; low ADDR_W bits of the 32-bit byte address
//  BNE_EN    0              1: decode bne (op 1100011, funct3 001); 0: treat bne as illegal
// PORTS
//  clk            in   1       clock, all state changes on posedge
//  rst            in   1       reset, synchronous, active-low
//  mem_req        out  1       memory transaction request
//  mem_we         out  1       1 = store word, 0 = read word (fetch or load)
//  mem_addr       out  ADDR_W  byte address, always word aligned when mem_req=1
//  mem_wdata      out  32      store data (rs2)
//  mem_rdata      in   32      read data, sampled on the edge where mem_req&mem_ready
//  mem_ready      in   1       completes the current transaction at this edge
//  instr_retired  out  1       high for the single final cycle of each completed instruction
//  halted         out  1       core stopped (illegal opcode or misaligned access/target)
// BEHAVIOUR
//  Reset: when rst=0 at a posedge -> state=FETCH, PC=RESET_PC, x1..x31=0, IR/A/B/ALUOut/MDR=0.
//   All outputs are 0 while rst=0. Reset applies mid-instruction and mid-transaction; a pending store is dropped.
//  Registers: 32x32. x0 reads 0; writes to x0 are discarded.
//  Handshake: mem_addr, mem_we and mem_wdata are held stable while mem_req=1 and mem_ready=0.
//   A transaction completes at the posedge where mem_req=1 and mem_ready=1.
//   mem_ready is ignored when mem_req=0. At most one transaction per state visit.
//  FSM (states and transitions):
//   FETCH    req, addr=PC. On ready: IR<=rdata, OldPC<=PC, PC<=PC+4 -> DECODE. Otherwise stay.
//   DECODE   A<=rs1, B<=rs2, imm extended (I/S/B/J). Next state by opcode:
//            lw/sw -> MEMADR; R-type -> EXEC_R; I-ALU -> EXEC_I; beq/bne -> BRANCH; jal -> JAL;
//            any other opcode or funct3 -> HALT.
//   MEMADR   ALUOut<=A+imm. Low 2 bits != 0 -> HALT. Otherwise lw -> MEMREAD, sw -> MEMWRITE.
//   MEMREAD  req, we=0, addr=ALUOut. On ready: MDR<=rdata -> MEMWB.
//   MEMWB    rd<=MDR, retire -> FETCH.
//   MEMWRITE req, we=1, wdata=B. On ready: retire -> FETCH.
//   EXEC_R   ALUOut<=A op B (sub when funct7[5]=1 and funct3=000) -> ALUWB.
//   EXEC_I   ALUOut<=A op imm (never sub) -> ALUWB.
//   ALUWB    rd<=ALUOut, retire -> FETCH.
//   BRANCH   If taken (beq: A==B; bne: A!=B), PC<=OldPC+imm. Taken target[1:0]!=0 -> HALT.
//            Otherwise retire -> FETCH.
//   JAL      ALUOut<=OldPC+4, PC<=OldPC+immJ. Target[1:0]!=0 -> HALT, otherwise -> ALUWB.
//   HALT     halted=1, mem_req=0, no register or PC change. Left only by reset.
//  ALU: 32-bit wraparound add/sub. slt/slti are signed: result 1 if A<B as signed, else 0.
//   Overflow is ignored.
//  Latency with zero wait states (cycles, each memory wait cycle adds 1):
//   beq/bne = 3; R-type, I-ALU, sw, jal = 4; lw = 5.
//  instr_retired is asserted in MEMWB, ALUWB, MEMWRITE (ready cycle) and BRANCH (no halt).
//   It is never asserted for a halting instruction.
// TESTING
//  1. Hold rst=0 for 3 cycles with mem_ready=1 -> mem_req=0, halted=0.
//     First cycle after release: mem_req=1, mem_addr=RESET_PC, mem_we=0.
//  2. Zero-wait program: addi x5,x0,2; add x6,x5,x5; slt x7,x5,x6; sub x7,x5,x7; ori x6,x6,30;
//     andi x5,x7,30; and x7,x7,x6; beq x5,x7,+8; or (skipped); slti x5,x5,1; sw x6,0(x0); lw x5,0(x0)
//     -> word 0 = 30, final x5=30, x6=30, x7=0; exactly 11 retire pulses; beq takes 3 cycles, lw 5.
//  3. mem_ready=0 for 3 cycles during a FETCH and during a sw -> mem_addr/mem_we/mem_wdata stable throughout;
//     each instruction completes exactly 3 cycles later than the zero-wait case; one write only.
//  4. Instruction 32'h0000_0000 -> halted=1 two cycles after the fetch completes; mem_req stays 0 for 20+ cycles;
//     rst=0 then clears halted and refetches RESET_PC.
//  5. addi x1,x0,2; lw x2,0(x1) -> HALT from MEMADR, no data mem_req.
//     addi x0,x0,5; add x3,x0,x0; sw x3,4(x0) -> word 1 = 0.
//  6. bne x0,x1,+8 with x1=1: BNE_EN=0 -> halted=1; BNE_EN=1 -> taken, next fetch address = bne address + 8.
//     Assert rst=0 mid-MEMREAD with mem_ready=0 -> next-cycle state FETCH at RESET_PC, x1..x31=0.

Source files
------------

// File: rtl/multi_cycle_processor_if.sv
// multi_cycle_processor_if: shared instruction/data memory port with req/ready handshake
interface multi_cycle_processor_if #(parameter int ADDR_W = 32);
  logic req;
  logic we;
  logic ready;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master(output req, we, addr, wdata, input rdata, ready);
  modport slave(input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/multi_cycle_processor.sv
// multi_cycle_processor: multicycle RV32 subset core on one shared memory port; halts on illegal or misaligned ops
module multi_cycle_processor #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int ADDR_W = 32,
  parameter bit BNE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  multi_cycle_processor_if.master mem,
  output logic instr_retired,
  output logic halted
);
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, HALT
  } state_t;
  state_t state, next;
  logic [31:0] pc, old_pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];
  logic [31:0] imm, src_b, alu_res, sum_adr, tgt, addr_full;
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic done, taken, legal_alu, sub;
  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign rd = ir[11:7];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign done = mem.req & mem.ready;
  assign legal_alu = f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010;
  always_comb begin
    imm = op == OP_SW ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
          op == OP_BR ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
          op == OP_JAL ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
          {{20{ir[31]}}, ir[31:20]};
    src_b = state == EXEC_R ? b : imm;
    sub = state == EXEC_R && ir[30] && f3 == 3'b000;
    alu_res = f3 == 3'b111 ? a & src_b :
              f3 == 3'b110 ? a | src_b :
              f3 == 3'b010 ? {31'b0, $signed(a) < $signed(src_b)} :
              sub ? a - src_b : a + src_b;
    sum_adr = a + imm;
    tgt = old_pc + imm;
    taken = f3[0] ? a != b : a == b;
    addr_full = state == FETCH ? pc : alu_out;
  end
  always_comb begin
    next = state;
    case (state)
      FETCH:    next = done ? DECODE : FETCH;
      DECODE:   next = (op == OP_LW || op == OP_SW) && f3 == 3'b010 ? MEMADR :
                       op == OP_R && legal_alu ? EXEC_R :
                       op == OP_I && legal_alu ? EXEC_I :
                       op == OP_BR && (f3 == 3'b000 || (BNE_EN && f3 == 3'b001)) ? BRANCH :
                       op == OP_JAL ? JAL : HALT;
      MEMADR:   next = sum_adr[1:0] != 2'b00 ? HALT : op == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:  next = done ? MEMWB : MEMREAD;
      MEMWB:    next = FETCH;
      MEMWRITE: next = done ? FETCH : MEMWRITE;
      EXEC_R:   next = ALUWB;
      EXEC_I:   next = ALUWB;
      ALUWB:    next = FETCH;
      BRANCH:   next = taken && tgt[1:0] != 2'b00 ? HALT : FETCH;
      JAL:      next = tgt[1:0] != 2'b00 ? HALT : ALUWB;
      default:  next = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      old_pc <= '0;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state <= next;
      if (state == FETCH && done) begin
        ir <= mem.rdata;
        old_pc <= pc;
        pc <= pc + 32'd4;
      end
      if (state == DECODE) begin
        a <= rf[rs1];
        b <= rf[rs2];
      end
      if (state == MEMADR) alu_out <= sum_adr;
      if (state == MEMREAD && done) mdr <= mem.rdata;
      if (state == EXEC_R || state == EXEC_I) alu_out <= alu_res;
      if (state == JAL) alu_out <= old_pc + 32'd4;
      if ((state == JAL || (state == BRANCH && taken)) && tgt[1:0] == 2'b00) pc <= tgt;
      if ((state == ALUWB || state == MEMWB) && rd != 5'd0) rf[rd] <= state == ALUWB ? alu_out : mdr;
    end
  end
  assign mem.req = rst && (state == FETCH || state == MEMREAD || state == MEMWRITE);
  assign mem.we = rst && state == MEMWRITE;
  assign mem.addr = rst ? addr_full[ADDR_W-1:0] : '0;
  assign mem.wdata = rst ? b : '0;
  assign halted = rst && state == HALT;
  assign instr_retired = rst && (state == MEMWB || state == ALUWB || (state == MEMWRITE && done) ||
                                 (state == BRANCH && !(taken && tgt[1:0] != 2'b00)));
endmodule

// File: tb/tb_multi_cycle_processor.sv
// tb_multi_cycle_processor: directed programs with hand-computed results, wait states, halts and reset
module tb_multi_cycle_processor;
  localparam logic [6:0] OPI = 7'b0010011, OPLW = 7'b0000011;
  logic clk = 0, rst = 0, load = 0;
  logic halted, retired, halted1, retired1;
  logic [31:0] prog [64];
  logic [31:0] mem_w [64];
  int ret_cyc [32];
  int checks = 0, errors = 0, cyc, nret, nwr, nxfer;
  multi_cycle_processor_if #(.ADDR_W(32)) mif();
  multi_cycle_processor_if #(.ADDR_W(32)) mif1();
  multi_cycle_processor #(.RESET_PC(32'h0), .ADDR_W(32), .BNE_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .mem(mif), .instr_retired(retired), .halted(halted));
  multi_cycle_processor #(.RESET_PC(32'h0), .ADDR_W(32), .BNE_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .mem(mif1), .instr_retired(retired1), .halted(halted1));
  assign mif.rdata = mem_w[mif.addr[7:2]];
  assign mif1.rdata = mem_w[mif1.addr[7:2]];
  assign mif1.ready = mif.ready;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (load) for (int i = 0; i < 64; i++) mem_w[i] <= prog[i];
    else if (mif.req && mif.ready && mif.we) mem_w[mif.addr[7:2]] <= mif.wdata;
    if (!rst) begin
      cyc <= 0;
      nret <= 0;
      nwr <= 0;
      nxfer <= 0;
    end else begin
      cyc <= cyc + 1;
      if (retired) begin
        if (nret < 32) ret_cyc[nret] <= cyc + 1;
        nret <= nret + 1;
      end
      if (mif.req && mif.ready) begin
        nxfer <= nxfer + 1;
        if (mif.we) nwr <= nwr + 1;
      end
    end
  end
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic clear();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
  endtask
  task automatic boot();
    rst = 0;
    load = 1;
    tick();
    load = 0;
    rst = 1;
  endtask
  task automatic wait_halt(int lim);
    int k = 0;
    while (!halted && k < lim) begin
      tick();
      k++;
    end
    check("halt_reached", halted, 1);
  endtask
  initial begin
    int k, seen;
    mif.ready = 1;
    clear();
    prog[0] = enc_i(2, 0, 3'b000, 5, OPI);
    prog[1] = enc_r(0, 5, 5, 3'b000, 6);
    prog[2] = enc_r(0, 6, 5, 3'b010, 7);
    prog[3] = enc_r(7'h20, 7, 5, 3'b000, 7);
    prog[4] = enc_i(30, 6, 3'b110, 6, OPI);
    prog[5] = enc_i(30, 7, 3'b111, 5, OPI);
    prog[6] = enc_r(0, 6, 7, 3'b111, 7);
    prog[7] = enc_b(8, 7, 5, 3'b000);
    prog[8] = enc_r(0, 6, 6, 3'b110, 5);
    prog[9] = enc_i(1, 5, 3'b010, 5, OPI);
    prog[10] = enc_s(0, 6, 0);
    prog[11] = enc_i(0, 0, 3'b010, 5, OPLW);
    rst = 0;
    load = 1;
    tick();
    load = 0;
    tick(2);
    check("rst_req", mif.req, 0);
    check("rst_halted", halted, 0);
    check("rst_retired", retired, 0);
    rst = 1;
    #1;
    check("boot_req", mif.req, 1);
    check("boot_addr", mif.addr, 0);
    check("boot_we", mif.we, 0);
    wait_halt(200);
    check("prog_x5", dut.rf[5], 30);
    check("prog_x6", dut.rf[6], 30);
    check("prog_x7", dut.rf[7], 0);
    check("prog_word0", mem_w[0], 30);
    check("prog_retires", nret, 11);
    check("prog_writes", nwr, 1);
    check("addi_latency", ret_cyc[0], 4);
    check("beq_latency", ret_cyc[7] - ret_cyc[6], 3);
    check("sw_latency", ret_cyc[9] - ret_cyc[8], 4);
    check("lw_latency", ret_cyc[10] - ret_cyc[9], 5);
    // wait states: three stalled cycles on the first fetch and on the store
    clear();
    prog[0] = enc_i(7, 0, 3'b000, 6, OPI);
    prog[1] = enc_s(8, 6, 0);
    rst = 0;
    load = 1;
    tick();
    load = 0;
    mif.ready = 0;
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fwait_req", mif.req, 1);
      check("fwait_addr", mif.addr, 0);
      check("fwait_we", mif.we, 0);
    end
    mif.ready = 1;
    k = 0;
    while (!mif.we && k < 50) begin
      tick();
      k++;
    end
    check("sw_seen", mif.we, 1);
    mif.ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("swait_addr", mif.addr, 8);
      check("swait_we", mif.we, 1);
      check("swait_wdata", mif.wdata, 7);
    end
    mif.ready = 1;
    wait_halt(50);
    check("wait_addi_ret", ret_cyc[0], 7);
    check("wait_sw_lat", ret_cyc[1] - ret_cyc[0], 7);
    check("wait_writes", nwr, 1);
    check("wait_word2", mem_w[2], 7);
    // all-zero instruction is illegal
    clear();
    boot();
    tick();
    check("ill_halted_early", halted, 0);
    tick();
    check("ill_halted", halted, 1);
    check("ill_retired", retired, 0);
    seen = 0;
    repeat (25) begin
      tick();
      seen += int'(mif.req);
    end
    check("ill_req_quiet", seen, 0);
    check("ill_xfers", nxfer, 1);
    rst = 0;
    #1;
    check("ill_rst_halted", halted, 0);
    tick();
    rst = 1;
    #1;
    check("ill_refetch_req", mif.req, 1);
    check("ill_refetch_addr", mif.addr, 0);
    // misaligned load address halts before any data request
    clear();
    prog[0] = enc_i(2, 0, 3'b000, 1, OPI);
    prog[1] = enc_i(0, 1, 3'b010, 2, OPLW);
    boot();
    wait_halt(50);
    tick(10);
    check("mis_xfers", nxfer, 2);
    check("mis_retires", nret, 1);
    check("mis_x1", dut.rf[1], 2);
    check("mis_x2", dut.rf[2], 0);
    // x0 stays zero; the store overwrites the add instruction word
    clear();
    prog[0] = enc_i(5, 0, 3'b000, 0, OPI);
    prog[1] = enc_r(0, 0, 0, 3'b000, 3);
    prog[2] = enc_s(4, 3, 0);
    boot();
    wait_halt(50);
    check("x0_word1", mem_w[1], 0);
    check("x0_x3", dut.rf[3], 0);
    check("x0_retires", nret, 3);
    // bne: illegal without BNE_EN, taken with it
    clear();
    prog[0] = enc_i(1, 0, 3'b000, 1, OPI);
    prog[1] = enc_b(8, 1, 0, 3'b001);
    prog[2] = enc_i(9, 0, 3'b000, 4, OPI);
    boot();
    tick(7);
    check("bne_off_halted", halted, 1);
    check("bne_on_halted", halted1, 0);
    check("bne_on_req", mif1.req, 1);
    check("bne_on_addr", mif1.addr, 12);
    // reset while a load waits for ready
    clear();
    prog[0] = enc_i(8, 0, 3'b000, 1, OPI);
    prog[1] = enc_i(0, 1, 3'b010, 2, OPLW);
    prog[2] = 32'h1234_5678;
    boot();
    k = 0;
    while (!(mif.req && !mif.we && mif.addr == 32'd8) && k < 50) begin
      tick();
      k++;
    end
    check("memread_addr", mif.addr, 8);
    mif.ready = 0;
    tick();
    rst = 0;
    #1;
    check("midrst_req", mif.req, 0);
    tick();
    check("midrst_x1", dut.rf[1], 0);
    check("midrst_x2", dut.rf[2], 0);
    mif.ready = 1;
    rst = 1;
    #1;
    check("midrst_req_after", mif.req, 1);
    check("midrst_addr", mif.addr, 0);
    check("midrst_we", mif.we, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
